// File: rtl/addsub_accumulator_ctrl.sv
// Command-driven accumulator wrapped around an external combinational 4-bit adder-subtractor.
// Registers its operands, captures Result/Cout and derives C/V/Z/N status flags.
module addsub_accumulator_ctrl #(
    parameter int unsigned     WIDTH     = 4,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_sub,
    input  logic [WIDTH-1:0] add_result,
    input  logic             add_cout,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n,
    output logic             done,
    output logic             busy
);

    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             add_sub_q, add_sub_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_v_q, flag_v_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             handshake_c;
    logic             ovf_c;

    // ready_q mirrors (state_q == ST_IDLE) so the handshake uses a registered term
    assign handshake_c = cmd_valid & ready_q;

    // Signed overflow: operand signs compared against the result sign
    always_comb begin
        ovf_c = 1'b0;
        if (add_sub_q) begin
            ovf_c = (acc_q[MSB] != add_b_q[MSB]) && (add_result[MSB] != acc_q[MSB]);
        end else begin
            ovf_c = (acc_q[MSB] == add_b_q[MSB]) && (add_result[MSB] != acc_q[MSB]);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (handshake_c) begin
                    if (cmd_op == OP_ADD || cmd_op == OP_SUB) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and status next values
    always_comb begin
        acc_d     = acc_q;
        add_b_d   = add_b_q;
        add_sub_d = add_sub_q;
        flag_c_d  = flag_c_q;
        flag_v_d  = flag_v_q;
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
        ready_d   = (state_d == ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);

        unique case (state_q)
            ST_IDLE: begin
                if (handshake_c) begin
                    unique case (cmd_op)
                        OP_LOAD: begin
                            acc_d    = cmd_data;
                            flag_z_d = (cmd_data == '0);
                            flag_n_d = cmd_data[MSB];
                            flag_c_d = 1'b0;
                            flag_v_d = 1'b0;
                        end
                        OP_CLEAR: begin
                            acc_d    = '0;
                            flag_z_d = 1'b1;
                            flag_n_d = 1'b0;
                            flag_c_d = 1'b0;
                            flag_v_d = 1'b0;
                        end
                        default: begin
                            add_b_d   = cmd_data;
                            add_sub_d = (cmd_op == OP_SUB);
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                acc_d    = add_result;
                flag_c_d = add_cout;
                flag_z_d = (add_result == '0);
                flag_n_d = add_result[MSB];
                flag_v_d = ovf_c;
            end
            default: ;
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= ACC_RESET;
            add_b_q   <= '0;
            add_sub_q <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_v_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            add_b_q   <= add_b_d;
            add_sub_q <= add_sub_d;
            flag_c_q  <= flag_c_d;
            flag_v_q  <= flag_v_d;
            flag_z_q  <= flag_z_d;
            flag_n_q  <= flag_n_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign cmd_ready = ready_q;
    assign add_a     = acc_q;
    assign add_b     = add_b_q;
    assign add_sub   = add_sub_q;
    assign acc       = acc_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_addsub_accumulator_ctrl.sv
// Directed bench for addsub_accumulator_ctrl with a behavioural adder-subtractor attached.
module tb_addsub_accumulator_ctrl;

    localparam int unsigned WIDTH = 4;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_sub;
    logic [WIDTH-1:0] add_result;
    logic             add_cout;
    logic [WIDTH-1:0] acc;
    logic             flag_c, flag_v, flag_z, flag_n;
    logic             done;
    logic             busy;
    logic [3:0]       flags;

    int compared;
    int mismatched;

    addsub_accumulator_ctrl #(.WIDTH(WIDTH), .ACC_RESET(4'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sub    (add_sub),
        .add_result (add_result),
        .add_cout   (add_cout),
        .acc        (acc),
        .flag_c     (flag_c),
        .flag_v     (flag_v),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .done       (done),
        .busy       (busy)
    );

    assign flags = {flag_c, flag_v, flag_z, flag_n};

    // Reference adder-subtractor: A + B, or A + ~B + 1 for subtract
    always_comb begin
        logic [WIDTH:0] sum;
        if (add_sub) begin
            sum = {1'b0, add_a} + {1'b0, ~add_b} + (WIDTH+1)'(1);
        end else begin
            sum = {1'b0, add_a} + {1'b0, add_b};
        end
        add_result = sum[WIDTH-1:0];
        add_cout   = sum[WIDTH];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a command at the current negedge; returns #1 after the accepting edge
    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 4'hA;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_data  = 4'h5;
        repeat (3) @(negedge clk);
        compared++;
        if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        compared++;
        if (acc !== 4'h0) begin mismatched++; $display("FAIL reset_acc got=%h exp=0", acc); end
        compared++;
        if (flags !== 4'b0000) begin mismatched++; $display("FAIL reset_flags got=%b exp=0000", flags); end
        compared++;
        if ({done, busy, add_sub} !== 3'b000) begin mismatched++; $display("FAIL reset_done_busy_sub got=%b exp=000", {done, busy, add_sub}); end
        compared++;
        if (add_b !== 4'h0) begin mismatched++; $display("FAIL reset_add_b got=%h exp=0", add_b); end
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load;
        send(OP_LOAD, 4'h7);
        @(negedge clk);
        compared++;
        if (acc !== 4'h7) begin mismatched++; $display("FAIL load_acc got=%h exp=7", acc); end
        compared++;
        if ({done, busy, cmd_ready} !== 3'b110) begin mismatched++; $display("FAIL load_ctl got=%b exp=110", {done, busy, cmd_ready}); end
        compared++;
        if (flags !== 4'b0000) begin mismatched++; $display("FAIL load_flags got=%b exp=0000", flags); end
        @(negedge clk);
        compared++;
        if ({done, busy, cmd_ready} !== 3'b001) begin mismatched++; $display("FAIL load_after got=%b exp=001", {done, busy, cmd_ready}); end
    endtask

    task automatic test_add_overflow;
        send(OP_ADD, 4'h1);
        @(negedge clk);
        compared++;
        if ({add_a, add_b, add_sub} !== {4'h7, 4'h1, 1'b0}) begin mismatched++; $display("FAIL add_exec_ops got=%h/%h/%b exp=7/1/0", add_a, add_b, add_sub); end
        compared++;
        if ({done, busy, cmd_ready} !== 3'b010) begin mismatched++; $display("FAIL add_exec_ctl got=%b exp=010", {done, busy, cmd_ready}); end
        compared++;
        if (acc !== 4'h7) begin mismatched++; $display("FAIL add_exec_acc got=%h exp=7", acc); end
        @(negedge clk);
        compared++;
        if (acc !== 4'h8) begin mismatched++; $display("FAIL add_acc got=%h exp=8", acc); end
        compared++;
        if (flags !== 4'b0101) begin mismatched++; $display("FAIL add_flags cvzn got=%b exp=0101", flags); end
        compared++;
        if (done !== 1'b1) begin mismatched++; $display("FAIL add_done got=%b exp=1", done); end
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL add_done_once got=%b exp=0", done); end
    endtask

    task automatic test_sub;
        send(OP_LOAD, 4'h3);
        repeat (2) @(negedge clk);
        send(OP_SUB, 4'h5);
        @(negedge clk);
        compared++;
        if ({add_a, add_b, add_sub} !== {4'h3, 4'h5, 1'b1}) begin mismatched++; $display("FAIL sub_exec_ops got=%h/%h/%b exp=3/5/1", add_a, add_b, add_sub); end
        @(negedge clk);
        compared++;
        if (acc !== 4'hE) begin mismatched++; $display("FAIL sub_borrow_acc got=%h exp=e", acc); end
        compared++;
        if (flags !== 4'b0001) begin mismatched++; $display("FAIL sub_borrow_flags cvzn got=%b exp=0001", flags); end
        @(negedge clk);
        send(OP_LOAD, 4'h5);
        repeat (2) @(negedge clk);
        send(OP_SUB, 4'h5);
        repeat (2) @(negedge clk);
        compared++;
        if (acc !== 4'h0) begin mismatched++; $display("FAIL sub_zero_acc got=%h exp=0", acc); end
        compared++;
        if (flags !== 4'b1010) begin mismatched++; $display("FAIL sub_zero_flags cvzn got=%b exp=1010", flags); end
        @(negedge clk);
        // Signed overflow on subtract: 8 - 1 = 7
        send(OP_LOAD, 4'h8);
        repeat (2) @(negedge clk);
        send(OP_SUB, 4'h1);
        repeat (2) @(negedge clk);
        compared++;
        if ({acc, flags} !== {4'h7, 4'b1100}) begin mismatched++; $display("FAIL sub_ovf got=%h/%b exp=7/1100", acc, flags); end
        @(negedge clk);
    endtask

    task automatic test_wrap_clear;
        send(OP_LOAD, 4'hF);
        repeat (2) @(negedge clk);
        compared++;
        if (flags !== 4'b0001) begin mismatched++; $display("FAIL load_neg_flags cvzn got=%b exp=0001", flags); end
        send(OP_ADD, 4'h1);
        repeat (2) @(negedge clk);
        compared++;
        if ({acc, flags} !== {4'h0, 4'b1010}) begin mismatched++; $display("FAIL wrap got=%h/%b exp=0/1010", acc, flags); end
        repeat (3) @(negedge clk);
        compared++;
        if ({acc, flags, done} !== {4'h0, 4'b1010, 1'b0}) begin mismatched++; $display("FAIL hold got=%h/%b/%b exp=0/1010/0", acc, flags, done); end
        send(OP_CLEAR, 4'h9);
        @(negedge clk);
        compared++;
        if ({acc, flags, done} !== {4'h0, 4'b0010, 1'b1}) begin mismatched++; $display("FAIL clear got=%h/%b/%b exp=0/0010/1", acc, flags, done); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int hs_cnt;
        send(OP_LOAD, 4'h0);
        repeat (2) @(negedge clk);
        hs_cnt    = 0;
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_data  = 4'h1;
        for (int c = 0; c < 9; c++) begin
            if (cmd_ready && cmd_valid) hs_cnt++;
            compared++;
            if (cmd_ready !== ((c % 3) == 0)) begin mismatched++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", c, cmd_ready, (c % 3) == 0); end
            compared++;
            if (done !== ((c % 3) == 2)) begin mismatched++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", c, done, (c % 3) == 2); end
            compared++;
            if (acc !== 4'((c + 1) / 3)) begin mismatched++; $display("FAIL b2b_acc cyc=%0d got=%h exp=%h", c, acc, 4'((c + 1) / 3)); end
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        compared++;
        if (hs_cnt != 3) begin mismatched++; $display("FAIL b2b_handshakes got=%0d exp=3", hs_cnt); end
        compared++;
        if (acc !== 4'h3) begin mismatched++; $display("FAIL b2b_final_acc got=%h exp=3", acc); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec;
        send(OP_LOAD, 4'h4);
        repeat (2) @(negedge clk);
        send(OP_ADD, 4'h2);
        @(negedge clk);
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL abort_in_exec got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        compared++;
        if ({acc, flags, done, busy, cmd_ready} !== {4'h0, 4'b0000, 3'b001}) begin
            mismatched++; $display("FAIL abort_state got=%h/%b/%b exp=0/0000/001", acc, flags, {done, busy, cmd_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if ({acc, done} !== {4'h0, 1'b0}) begin mismatched++; $display("FAIL abort_no_done got=%h/%b exp=0/0", acc, done); end
        send(OP_ADD, 4'h3);
        repeat (2) @(negedge clk);
        compared++;
        if ({acc, flags, done} !== {4'h3, 4'b0000, 1'b1}) begin mismatched++; $display("FAIL abort_recover got=%h/%b/%b exp=3/0000/1", acc, flags, done); end
        @(negedge clk);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = OP_LOAD;
        cmd_data   = 4'h0;
        @(negedge clk);
        test_reset;
        test_load;
        test_add_overflow;
        test_sub;
        test_wrap_clear;
        test_back_to_back;
        test_reset_mid_exec;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
